multicycle_control: RTL and testbench

Sequencing controller for the multicycle version of the MIPS CPU datapath. It replaces the single-cycle combinational control, so one shared memory, the main ALU and the register file can be reused across several cycles per instruction. It is a Moore FSM that takes the instruction opcode/funct, the ALU zero flag and a memory ready handshake. It drives every datapath enable and select, plus a retire pulse and a sticky illegal-opcode flag.

---
 rtl/mips_pkg.sv | 80 ++++++++
 rtl/ctrl_decode.sv | 107 ++++++++++
 rtl/multicycle_control.sv | 87 ++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct, FSM states, selects.
// Latency: none (constants, types and a pure decode helper).
// Backpressure: n/a.
// Contents: opcode/funct constants, datapath select encodings, stateT enum,
//           ctrlT control vector, decodeNext() helper for the DECODE dispatch.
package mips_pkg;

  localparam logic [5:0] opRtype = 6'b000000;
  localparam logic [5:0] opJ     = 6'b000010;
  localparam logic [5:0] opJal   = 6'b000011;
  localparam logic [5:0] opBeq   = 6'b000100;
  localparam logic [5:0] opBne   = 6'b000101;
  localparam logic [5:0] opAddi  = 6'b001000;
  localparam logic [5:0] opXori  = 6'b001110;
  localparam logic [5:0] opLw    = 6'b100011;
  localparam logic [5:0] opSw    = 6'b101011;

  localparam logic [5:0] functJr = 6'b001000;

  localparam logic [1:0] aluAdd   = 2'b00;
  localparam logic [1:0] aluSub   = 2'b01;
  localparam logic [1:0] aluFunct = 2'b10;
  localparam logic [1:0] aluXor   = 2'b11;

  localparam logic [1:0] srcBRt    = 2'b00;
  localparam logic [1:0] srcB4     = 2'b01;
  localparam logic [1:0] srcBImm   = 2'b10;
  localparam logic [1:0] srcBImmSh = 2'b11;

  localparam logic [1:0] pcAlu    = 2'b00;
  localparam logic [1:0] pcAluOut = 2'b01;
  localparam logic [1:0] pcJump   = 2'b10;
  localparam logic [1:0] pcRs     = 2'b11;

  localparam logic [1:0] dstRt = 2'b00;
  localparam logic [1:0] dstRd = 2'b01;
  localparam logic [1:0] dstRa = 2'b10;

  localparam logic [1:0] wbAluOut = 2'b00;
  localparam logic [1:0] wbMdr    = 2'b01;
  localparam logic [1:0] wbPc     = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB,
    IEXEC, IWB, BRANCH, JUMP, JAL, JR, HALT
  } stateT;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       iord;
    logic       irWrite;
    logic       pcEn;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       extZero;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       retire;
  } ctrlT;

  // Where DECODE dispatches to; HALT doubles as the illegal-opcode marker.
  function automatic stateT decodeNext(input logic [5:0] opcode, input logic [5:0] funct);
    stateT nxt;
    case (opcode)
      opLw, opSw:     nxt = MEMADR;
      opRtype:        nxt = (funct == functJr) ? JR : REXEC;
      opAddi, opXori: nxt = IEXEC;
      opBeq, opBne:   nxt = BRANCH;
      opJ:            nxt = JUMP;
      opJal:          nxt = JAL;
      default:        nxt = HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from FSM state (plus opcode, zero, memReady) to the datapath control vector.
// Latency: 0 cycles, purely combinational.
// Backpressure: memReady only qualifies the FETCH load enables and the store retire.
// Ports: state (current FSM state), opcode (IR opcode), zero (ALU zero flag),
//        memReady (memory done this cycle), ctrl (full control vector, unqualified by reset).
module ctrl_decode
  import mips_pkg::*;
(
  input  stateT       state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        memReady,
  output ctrlT        ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memReq   = 1'b1;
        ctrl.iord     = 1'b0;
        ctrl.aluSrcA  = 1'b0;
        ctrl.aluSrcB  = srcB4;
        ctrl.aluOp    = aluAdd;
        ctrl.irWrite  = memReady;
        ctrl.pcEn     = memReady;
        ctrl.pcSource = pcAlu;
      end
      DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ctrl.aluSrcB = srcBImmSh;
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = srcBImm;
      end
      MEMRD: begin
        ctrl.memReq = 1'b1;
        ctrl.iord   = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = dstRt;
        ctrl.memToReg = wbMdr;
        ctrl.retire   = 1'b1;
      end
      MEMWR: begin
        ctrl.memReq   = 1'b1;
        ctrl.memWrite = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.retire   = memReady;
      end
      REXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = srcBRt;
        ctrl.aluOp   = aluFunct;
      end
      RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = dstRd;
        ctrl.memToReg = wbAluOut;
        ctrl.retire   = 1'b1;
      end
      IEXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = srcBImm;
        ctrl.aluOp   = (opcode == opXori) ? aluXor : aluAdd;
        ctrl.extZero = (opcode == opXori);
      end
      IWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = dstRt;
        ctrl.memToReg = wbAluOut;
        ctrl.retire   = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = srcBRt;
        ctrl.aluOp    = aluSub;
        ctrl.pcSource = pcAluOut;
        ctrl.pcEn     = (opcode == opBne) ? ~zero : zero;
        ctrl.retire   = 1'b1;
      end
      JUMP: begin
        ctrl.pcEn     = 1'b1;
        ctrl.pcSource = pcJump;
        ctrl.retire   = 1'b1;
      end
      JAL: begin
        // PC register still holds PC+4 here, which is the link value.
        ctrl.pcEn     = 1'b1;
        ctrl.pcSource = pcJump;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = dstRa;
        ctrl.memToReg = wbPc;
        ctrl.retire   = 1'b1;
      end
      JR: begin
        ctrl.pcEn     = 1'b1;
        ctrl.pcSource = pcRs;
        ctrl.retire   = 1'b1;
      end
      default: ctrl = '0;  // HALT: everything off
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: state register, next-state logic, sticky illegal flag.
// Latency: lw 5, sw/R/addi/xori 4, branch/jump 3 cycles; +1 per mem_ready=0 cycle.
// Backpressure: stalls in FETCH/MEMRD/MEMWR with request held until mem_ready.
// Ports: clk, reset_n (async active-low); opcode/funct from IR; zero (ALU flag);
//        mem_ready; datapath enables/selects; retire pulse; illegal (sticky).
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_zero,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       illegal
);

  stateT state;
  stateT decodeState;
  ctrlT  ctrl;
  logic  illegalQ;

  assign decodeState = decodeNext(opcode, funct);

  ctrl_decode uDecode (
    .state    (state),
    .opcode   (opcode),
    .zero     (zero),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          state <= decodeState;
          if (decodeState == HALT) illegalQ <= 1'b1;
        end
        MEMADR: state <= (opcode == opSw) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWR:  if (mem_ready) state <= FETCH;
        REXEC:  state <= RWB;
        IEXEC:  state <= IWB;
        HALT:   state <= HALT;
        default: state <= FETCH;  // all writeback / PC-update states
      endcase
    end
  end

  // Enables are qualified by reset_n so an asserted reset kills them immediately,
  // while the state register already reads FETCH and selects show FETCH values.
  assign mem_req    = ctrl.memReq   & reset_n;
  assign mem_write  = ctrl.memWrite & reset_n;
  assign ir_write   = ctrl.irWrite  & reset_n;
  assign pc_en      = ctrl.pcEn     & reset_n;
  assign reg_write  = ctrl.regWrite & reset_n;
  assign retire     = ctrl.retire   & reset_n;
  assign iord       = ctrl.iord;
  assign pc_source  = ctrl.pcSource;
  assign alu_src_a  = ctrl.aluSrcA;
  assign alu_src_b  = ctrl.aluSrcB;
  assign alu_op     = ctrl.aluOp;
  assign ext_zero   = ctrl.extZero;
  assign reg_dst    = ctrl.regDst;
  assign mem_to_reg = ctrl.memToReg;
  assign illegal    = illegalQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push per-cycle
// expected output vectors; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       ext_zero, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       retire, illegal;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       iord;
    logic       irWrite;
    logic       pcEn;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       extZero;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       retire;
    logic       illegal;
  } obsT;

  typedef struct {
    obsT   v;
    string tag;
  } expT;

  expT sb[$];
  expT cur;
  obsT obs;
  int  checks = 0;
  int  failures = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_zero   (ext_zero),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .illegal    (illegal)
  );

  assign obs = {mem_req, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a,
                alu_src_b, alu_op, ext_zero, reg_write, reg_dst, mem_to_reg,
                retire, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vectors, written out by hand from the state tables.
  function automatic obsT fReset();
    obsT v = '0; v.aluSrcB = 2'b01; return v;
  endfunction
  function automatic obsT fFetch(input logic rdy);
    obsT v = '0; v.memReq = 1; v.aluSrcB = 2'b01; v.irWrite = rdy; v.pcEn = rdy; return v;
  endfunction
  function automatic obsT fDecode();
    obsT v = '0; v.aluSrcB = 2'b11; return v;
  endfunction
  function automatic obsT fMemAdr();
    obsT v = '0; v.aluSrcA = 1; v.aluSrcB = 2'b10; return v;
  endfunction
  function automatic obsT fMemRd();
    obsT v = '0; v.memReq = 1; v.iord = 1; return v;
  endfunction
  function automatic obsT fMemWb();
    obsT v = '0; v.regWrite = 1; v.memToReg = 2'b01; v.retire = 1; return v;
  endfunction
  function automatic obsT fMemWr(input logic rdy);
    obsT v = '0; v.memReq = 1; v.memWrite = 1; v.iord = 1; v.retire = rdy; return v;
  endfunction
  function automatic obsT fRexec();
    obsT v = '0; v.aluSrcA = 1; v.aluOp = 2'b10; return v;
  endfunction
  function automatic obsT fRwb();
    obsT v = '0; v.regWrite = 1; v.regDst = 2'b01; v.retire = 1; return v;
  endfunction
  function automatic obsT fIexec(input logic xori);
    obsT v = '0; v.aluSrcA = 1; v.aluSrcB = 2'b10;
    v.aluOp = xori ? 2'b11 : 2'b00; v.extZero = xori; return v;
  endfunction
  function automatic obsT fIwb();
    obsT v = '0; v.regWrite = 1; v.retire = 1; return v;
  endfunction
  function automatic obsT fBranch(input logic taken);
    obsT v = '0; v.aluSrcA = 1; v.aluOp = 2'b01; v.pcSource = 2'b01;
    v.pcEn = taken; v.retire = 1; return v;
  endfunction
  function automatic obsT fJump();
    obsT v = '0; v.pcEn = 1; v.pcSource = 2'b10; v.retire = 1; return v;
  endfunction
  function automatic obsT fJal();
    obsT v = '0; v.pcEn = 1; v.pcSource = 2'b10; v.regWrite = 1;
    v.regDst = 2'b10; v.memToReg = 2'b10; v.retire = 1; return v;
  endfunction
  function automatic obsT fJr();
    obsT v = '0; v.pcEn = 1; v.pcSource = 2'b11; v.retire = 1; return v;
  endfunction
  function automatic obsT fHalt();
    obsT v = '0; v.illegal = 1; return v;
  endfunction

  // Called at posedge+1: drive this cycle's inputs, queue its expectation, advance.
  task automatic step(input logic rdy, input logic z, input obsT v, input string tag);
    expT e;
    mem_ready = rdy;
    zero      = z;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares one queued expectation per cycle at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (obs !== cur.v) begin
        failures++;
        $display("FAIL %s: got %h expected %h", cur.tag, obs, cur.v);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    @(posedge clk);
    #1;

    // Reset: enables forced off even with mem_ready high.
    step(1, 0, fReset(), "reset_rdy1");
    step(0, 1, fReset(), "reset_rdy0");
    reset_n = 1'b1;

    // addi, zero-wait
    opcode = 6'b001000;
    step(1, 0, fFetch(1), "addi_fetch");
    step(1, 0, fDecode(), "addi_decode");
    step(1, 0, fIexec(0), "addi_iexec");
    step(1, 0, fIwb(), "addi_iwb");

    // xori
    opcode = 6'b001110;
    step(1, 0, fFetch(1), "xori_fetch");
    step(1, 1, fDecode(), "xori_decode");
    step(1, 0, fIexec(1), "xori_iexec");
    step(1, 0, fIwb(), "xori_iwb");

    // lw: 2 FETCH waits, 1 MEMRD wait -> 8 cycles; mem_ready low outside requests
    opcode = 6'b100011;
    step(0, 0, fFetch(0), "lw_fetch_wait0");
    step(0, 0, fFetch(0), "lw_fetch_wait1");
    step(1, 0, fFetch(1), "lw_fetch");
    step(0, 0, fDecode(), "lw_decode");
    step(1, 0, fMemAdr(), "lw_memadr");
    step(0, 0, fMemRd(), "lw_memrd_wait");
    step(1, 0, fMemRd(), "lw_memrd");
    step(0, 0, fMemWb(), "lw_memwb");

    // sw, zero-wait
    opcode = 6'b101011;
    step(1, 0, fFetch(1), "sw_fetch");
    step(1, 0, fDecode(), "sw_decode");
    step(1, 0, fMemAdr(), "sw_memadr");
    step(1, 0, fMemWr(1), "sw_memwr");

    // R-type add
    opcode = 6'b000000; funct = 6'b100000;
    step(1, 0, fFetch(1), "add_fetch");
    step(1, 0, fDecode(), "add_decode");
    step(1, 0, fRexec(), "add_rexec");
    step(1, 0, fRwb(), "add_rwb");

    // branches: taken/not-taken for both polarities
    opcode = 6'b000100;
    step(1, 0, fFetch(1), "beq1_fetch");
    step(1, 0, fDecode(), "beq1_decode");
    step(1, 1, fBranch(1), "beq_zero1");
    step(1, 0, fFetch(1), "beq0_fetch");
    step(1, 0, fDecode(), "beq0_decode");
    step(1, 0, fBranch(0), "beq_zero0");
    opcode = 6'b000101;
    step(1, 0, fFetch(1), "bne1_fetch");
    step(1, 0, fDecode(), "bne1_decode");
    step(1, 1, fBranch(0), "bne_zero1");
    step(1, 0, fFetch(1), "bne0_fetch");
    step(1, 0, fDecode(), "bne0_decode");
    step(1, 0, fBranch(1), "bne_zero0");

    // j, jal, jr
    opcode = 6'b000010;
    step(1, 0, fFetch(1), "j_fetch");
    step(1, 0, fDecode(), "j_decode");
    step(1, 0, fJump(), "j_jump");
    opcode = 6'b000011;
    step(1, 0, fFetch(1), "jal_fetch");
    step(1, 0, fDecode(), "jal_decode");
    step(1, 0, fJal(), "jal_jal");
    opcode = 6'b000000; funct = 6'b001000;
    step(1, 0, fFetch(1), "jal_next_fetch");
    step(1, 0, fDecode(), "jr_decode");
    step(1, 0, fJr(), "jr_jr");

    // illegal opcode: HALT with sticky flag, nothing enabled for 20 cycles
    opcode = 6'b111111;
    step(1, 0, fFetch(1), "ill_fetch");
    step(1, 0, fDecode(), "ill_decode");
    for (int i = 0; i < 20; i++)
      step(logic'(i % 2), logic'(i % 3 == 0), fHalt(), $sformatf("halt_%0d", i));
    reset_n = 1'b0;
    step(1, 0, fReset(), "halt_reset");
    reset_n = 1'b1;
    opcode = 6'b001000;
    step(1, 0, fFetch(1), "post_halt_fetch");
    step(1, 0, fDecode(), "post_halt_decode");
    step(1, 0, fIexec(0), "post_halt_iexec");
    step(1, 0, fIwb(), "post_halt_iwb");

    // reset mid-MEMWR: write must vanish before any clock edge
    opcode = 6'b101011;
    step(1, 0, fFetch(1), "swr_fetch");
    step(1, 0, fDecode(), "swr_decode");
    step(1, 0, fMemAdr(), "swr_memadr");
    step(0, 0, fMemWr(0), "swr_memwr_wait");
    reset_n = 1'b0;
    step(0, 0, fReset(), "swr_async_reset");
    reset_n = 1'b1;
    opcode = 6'b001000;
    step(1, 0, fFetch(1), "swr_after_fetch");
    step(1, 0, fDecode(), "swr_after_decode");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
